// File: rtl/mbox_pkg.sv
// Shared definitions for the side-A mailbox doorbell sequencer:
// FSM state encoding, mailbox register bit map and read-modify-write masks.
package mbox_pkg;

  localparam int MB_W = 6;

  localparam int MB_PEER_MP  = 0;
  localparam int MB_OWN_MP   = 1;
  localparam int MB_OWN_MPIE = 2;
  localparam int MB_PEER_ACK = 3;
  localparam int MB_OWN_ACK  = 4;
  localparam int MB_OWN_AIE  = 5;

  // Raise the peer message-pending bit; everything else is written back unchanged.
  localparam logic [MB_W-1:0] SET_MASK = MB_W'(1) << MB_PEER_MP;
  // Drop the peer ACK and peer MP handshake bits; own-side bits survive.
  localparam logic [MB_W-1:0] CLR_MASK = ~((MB_W'(1) << MB_PEER_ACK) | (MB_W'(1) << MB_PEER_MP));

  typedef enum logic [3:0] {
    IDLE,
    SET_RD,
    SET_RDW,
    SET_WR,
    ACK_WAIT,
    CLR_RD,
    CLR_RDW,
    CLR_WR,
    DONE
  } state_e;

  // Index width for an n-entry requester vector, never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mbox_doorbell_arb_rr_arbiter.sv
// Round-robin pick: first set request at or after the pointer, wrapping.
// Purely combinational.
module rr_arbiter
  import mbox_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic                  gnt_vld,
  output logic [idx_w(N)-1:0]   gnt_idx
);

  int pos;

  // Scan from the farthest slot back to the pointer so the closest match wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pos     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (req[pos]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx_w(N)'(pos);
      end
    end
  end

endmodule

// File: rtl/mbox_doorbell_arb.sv
// Side-A mailbox doorbell sequencer: arbitrates NUM_REQ requesters, raises the
// peer message-pending bit, waits for the peer ack (or times out), clears the
// handshake bits and pulses done to the owner.
// Optional build macro: MBOX_DOORBELL_STATS_EN adds sent_cnt / tmo_cnt counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no grant; pick next requester round-robin
// SET_RD   | mb_rd high: read mailbox before raising peer MP
// SET_RDW  | wait for read data; fold it into the set write
// SET_WR   | mb_wr high with read data | SET_MASK
// ACK_WAIT | wait for ack_irq or timeout (ack wins a tie)
// CLR_RD   | mb_rd high: read mailbox before clearing handshake bits
// CLR_RDW  | wait for read data; fold it into the clear write
// CLR_WR   | mb_wr high with read data & CLR_MASK
// DONE     | done[owner] (and err on timeout) high; advance rr pointer
module mbox_doorbell_arb
  import mbox_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          done,
  output logic                        err,
  output logic                        busy,
  output logic [idx_w(NUM_REQ)-1:0]   owner,
  output logic                        mb_wr,
  output logic                        mb_rd,
  output logic [MB_W-1:0]             mb_wdata,
  input  logic [MB_W-1:0]             mb_rdata,
  input  logic                        mb_rvalid,
  input  logic                        ack_irq
`ifdef MBOX_DOORBELL_STATS_EN
  ,
  output logic [15:0]                 sent_cnt,
  output logic [15:0]                 tmo_cnt
`endif
);

  localparam int OW = idx_w(NUM_REQ);
  localparam logic [NUM_REQ-1:0]   ONE_HOT0 = NUM_REQ'(1);
  localparam logic [OW-1:0]        LAST_IDX = OW'(NUM_REQ - 1);
  localparam logic [TIMEOUT_W:0]   TMO_LIM  = (TIMEOUT_W + 1)'(TIMEOUT_CYC);

  state_e                 state_q, state_d;
  logic [OW-1:0]          ptr_q, ptr_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic                   busy_q, busy_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   err_q, err_d;
  logic                   wr_q, wr_d;
  logic                   rd_q, rd_d;
  logic [MB_W-1:0]        wdata_q, wdata_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic                   tmo_q, tmo_d;

  logic                   gnt_vld;
  logic [OW-1:0]          gnt_idx;
  logic [TIMEOUT_W:0]     cnt_nxt;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Extra top bit lets the increment detect saturation and the limit compare.
  assign cnt_nxt = {1'b0, cnt_q} + 1'b1;

  // Next-state and next-output logic; outputs are set on entry to the state
  // that owns them, so each strobe is high for exactly that state's cycle.
  // The read data is folded straight into the write register, which doubles
  // as the shadow copy of the mailbox.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    done_d  = '0;
    err_d   = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_idx;
          busy_d  = 1'b1;
          rd_d    = 1'b1;
          state_d = SET_RD;
        end
      end
      SET_RD: state_d = SET_RDW;
      SET_RDW: begin
        if (mb_rvalid) begin
          wr_d    = 1'b1;
          wdata_d = mb_rdata | SET_MASK;
          state_d = SET_WR;
        end
      end
      SET_WR: begin
        cnt_d   = '0;
        state_d = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (ack_irq) begin
          tmo_d   = 1'b0;
          rd_d    = 1'b1;
          state_d = CLR_RD;
        end else begin
          if (!cnt_nxt[TIMEOUT_W]) cnt_d = cnt_nxt[TIMEOUT_W-1:0];
          if (cnt_nxt >= TMO_LIM) begin
            tmo_d   = 1'b1;
            rd_d    = 1'b1;
            state_d = CLR_RD;
          end
        end
      end
      CLR_RD: state_d = CLR_RDW;
      CLR_RDW: begin
        if (mb_rvalid) begin
          wr_d    = 1'b1;
          wdata_d = mb_rdata & CLR_MASK;
          state_d = CLR_WR;
        end
      end
      CLR_WR: begin
        done_d  = ONE_HOT0 << owner_q;
        err_d   = tmo_q;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign owner    = owner_q;
  assign mb_wr    = wr_q;
  assign mb_rd    = rd_q;
  assign mb_wdata = wdata_q;

`ifdef MBOX_DOORBELL_STATS_EN
  logic [15:0] sent_cnt_q, sent_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // Completion counters, bumped once per DONE; both wrap naturally.
  always_comb begin
    sent_cnt_d = sent_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    if (state_q == DONE) begin
      sent_cnt_d = sent_cnt_q + 16'd1;
      if (tmo_q) tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      sent_cnt_q <= sent_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign sent_cnt = sent_cnt_q;
  assign tmo_cnt  = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_mbox_doorbell_arb.sv
// Scoreboard bench for mbox_doorbell_arb with a mailbox/peer model.
module tb_mbox_doorbell_arb;

  localparam int N  = 4;
  localparam int T  = 10;
  localparam int OW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    done;
  logic            err, busy, mb_wr, mb_rd, mb_rvalid, ack_irq;
  logic [OW-1:0]   owner;
  logic [5:0]      mb_wdata, mb_rdata;
`ifdef MBOX_DOORBELL_STATS_EN
  logic [15:0]     sent_cnt, tmo_cnt;
`endif

  typedef struct {
    int owner;
    bit err;
    int lat;
  } exp_t;

  exp_t        expq[$];
  logic [5:0]  wq[$];
  logic [5:0]  rdq[$];
  int          aq[$];

  int checks = 0;
  int passes = 0;
  int m_ptr  = 0;
  bit mon_en = 1'b0;

  mbox_doorbell_arb #(
    .NUM_REQ     (N),
    .TIMEOUT_CYC (T),
    .TIMEOUT_W   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .owner     (owner),
    .mb_wr     (mb_wr),
    .mb_rd     (mb_rd),
    .mb_wdata  (mb_wdata),
    .mb_rdata  (mb_rdata),
    .mb_rvalid (mb_rvalid),
    .ack_irq   (ack_irq)
`ifdef MBOX_DOORBELL_STATS_EN
    ,
    .sent_cnt  (sent_cnt),
    .tmo_cnt   (tmo_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // sel: 0 = busy high, 1 = mb_wr high, 2 = any done
  task automatic wait_sig(input int sel, input string name);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       hit = busy;
        1:       hit = mb_wr;
        default: hit = (done != 0);
      endcase
    end
    if (!hit) begin
      checks++;
      $display("FAIL %s: event not seen within 200 cycles", name);
    end
  endtask

  // Reference: service order for requests all raised together is the
  // round-robin walk from the model pointer; ack delay d (cycles after the set
  // write's cycle+1) decides ok vs timeout and the grant-to-done latency.
  task automatic scenario(input logic [N-1:0] r, input int d_fixed, input bit use_rd,
                          input logic [5:0] rd0, input logic [5:0] rd1);
    logic [N-1:0] pend;
    int own, d, n;
    exp_t e;
    pend = r;
    while (pend != 0) begin
      own = -1;
      for (int k = 0; k < N; k++)
        if (own < 0 && pend[(m_ptr + k) % N]) own = (m_ptr + k) % N;
      pend[own] = 1'b0;
      m_ptr = (own + 1) % N;
      d = (d_fixed >= 0) ? d_fixed : int'($urandom_range(0, T + 2));
      e.owner = own;
      e.err   = (d >= T);
      e.lat   = 7 + ((d >= T) ? (T - 1) : d);
      expq.push_back(e);
      aq.push_back(d);
      if (use_rd) begin
        rdq.push_back(rd0);
        rdq.push_back(rd1);
      end
    end
    req = r;
    n = 0;
    while (req != 0 && n < 400) begin
      @(negedge clk);
      n++;
      if (done != 0) req = req & ~done;
    end
    if (req != 0) begin
      checks++;
      $display("FAIL scenario_drain: req still 0x%0h after 400 cycles", req);
      req = '0;
    end
    repeat (3) @(negedge clk);
  endtask

  // Mailbox: read data returned the cycle after mb_rd; records the write the
  // sequencer must issue for that read (set on even reads, clear on odd).
  initial begin : mailbox_model
    bit prev_rd;
    int rd_n;
    logic [5:0] v;
    prev_rd = 1'b0;
    rd_n = 0;
    mb_rvalid = 1'b0;
    mb_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_rd = 1'b0;
        rd_n = 0;
        mb_rvalid = 1'b0;
      end else begin
        mb_rvalid = prev_rd;
        if (prev_rd) begin
          if (rdq.size() > 0) v = rdq.pop_front();
          else v = 6'($urandom);
          mb_rdata = v;
          wq.push_back((rd_n % 2 == 0) ? (v | 6'b000001) : (v & 6'b110110));
          rd_n++;
        end else begin
          mb_rdata = 6'($urandom);
        end
        prev_rd = mb_rd;
      end
    end
  end

  // Peer: one-cycle ack pulse d+1 cycles after each set write.
  initial begin : peer_model
    int cd;
    int wr_n;
    cd = 0;
    wr_n = 0;
    ack_irq = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ack_irq = 1'b0;
      if (reset) begin
        cd = 0;
        wr_n = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) ack_irq = 1'b1;
        end
        if (mb_wr) begin
          if (wr_n % 2 == 0 && aq.size() > 0) cd = aq.pop_front() + 1;
          wr_n++;
        end
      end
    end
  end

  initial begin : monitor
    int cyc, grant_cyc, m_sent, m_tmo;
    bit prev_busy, after;
    exp_t e;
    logic [5:0] w;
    cyc = 0;
    grant_cyc = 0;
    m_sent = 0;
    m_tmo = 0;
    prev_busy = 1'b0;
    after = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset || !mon_en) begin
        prev_busy = 1'b0;
        after = 1'b0;
      end else begin
        if (busy && !prev_busy) grant_cyc = cyc;
        if (after) begin
          after = 1'b0;
          check("busy_after_done", 32'(busy), 32'd0);
`ifdef MBOX_DOORBELL_STATS_EN
          check("sent_cnt", 32'(sent_cnt), 32'(m_sent));
          check("tmo_cnt", 32'(tmo_cnt), 32'(m_tmo));
`endif
        end
        if (mb_wr) begin
          check("rd_wr_excl", 32'(mb_rd), 32'd0);
          if (wq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_write: wdata 0x%0h with no read outstanding", mb_wdata);
          end else begin
            w = wq.pop_front();
            check("mb_wdata", 32'(mb_wdata), 32'(w));
          end
        end
        if (done != 0) begin
          if (expq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: done 0x%0h with nothing expected", done);
          end else begin
            e = expq.pop_front();
            check("done_vec", 32'(done), 32'(1) << e.owner);
            check("owner", 32'(owner), 32'(e.owner));
            check("err", 32'(err), 32'(e.err));
            check("latency", 32'(cyc - grant_cyc), 32'(e.lat));
            check("busy_at_done", 32'(busy), 32'd1);
            m_sent++;
            if (e.err) m_tmo++;
          end
          after = 1'b1;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : stim
    reset = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, owner, done, err, mb_wr, mb_rd, mb_wdata}), 32'd0);
    reset = 1'b0;

    // Move the pointer to 3, then reset mid-ACK_WAIT and mid-SET_RDW.
    req = 4'b0100;
    wait_sig(2, "warmup_done");
    req = '0;
    repeat (3) @(negedge clk);
    req = 4'b1010;
    wait_sig(0, "pre_reset_grant");
    check("pre_reset_owner", 32'(owner), 32'd3);
    wait_sig(1, "pre_reset_set_wr");
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset_async_ackwait", 32'({busy, owner, done, err, mb_wr, mb_rd, mb_wdata}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_sig(0, "post_reset_grant_a");
    check("post_reset_owner_a", 32'(owner), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset_async_setrdw", 32'({busy, owner, done, err, mb_wr, mb_rd, mb_wdata}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_sig(0, "post_reset_grant_b");
    check("post_reset_owner_b", 32'(owner), 32'd1);
    check("no_done_after_reset", 32'(done), 32'd0);
    reset = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    wq.delete();
    rdq.delete();
    aq.delete();
    expq.delete();
    m_ptr = 0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    scenario(4'b1111, 0, 1'b0, 6'd0, 6'd0);
    scenario(4'b0001, 0, 1'b0, 6'd0, 6'd0);
    scenario(4'b0010, 3, 1'b1, 6'b000100, 6'b001101);
    scenario(4'b0100, T + 2, 1'b0, 6'd0, 6'd0);
    scenario(4'b1000, T - 1, 1'b1, 6'b011011, 6'b111111);
    scenario(4'b0001, 1, 1'b1, 6'b100110, 6'b100110);
    scenario(4'b0010, T, 1'b0, 6'd0, 6'd0);
    for (int i = 0; i < 20; i++)
      scenario(N'($urandom_range(1, (1 << N) - 1)), -1, 1'b0, 6'd0, 6'd0);

    repeat (3) @(negedge clk);
    check("expq_drained", 32'(expq.size()), 32'd0);
    check("wq_drained", 32'(wq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
